// File: rtl/mandelbrot_pixel_packer_if.sv
// Byte stream leaving the pixel packer: packed nibble pairs with a
// start-of-frame flag on a valid/ready handshake.
interface mandelbrot_pixel_packer_if;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_sof, output out_valid, input out_ready);
    modport slave  (input out_data, input out_sof, input out_valid, output out_ready);
endinterface

// File: rtl/mandelbrot_pixel_packer.sv
// Paces the Mandelbrot core one pixel at a time, packs two 4-bit iteration
// counts per byte into a show-ahead FIFO and streams bytes out.
module mandelbrot_pixel_packer #(
    parameter int DEPTH  = 4,
    parameter int PIXELS = 76800,
    parameter int PCW    = $clog2(PIXELS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             core_running,
    input  logic [3:0]                       ctr_in,
    output logic                             run,
    output logic                             frame_done,
    output logic                             busy,
    mandelbrot_pixel_packer_if.master        out_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [PCW-1:0] LAST_PIX = PCW'(PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BUSY,
        S_FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
    logic [3:0]     half_q, half_d;
    logic           half_valid_q, half_valid_d;
    logic           sof_pending_q, sof_pending_d;
    logic           l_running_q, l_running_d;
    logic           run_q, run_d;
    logic           frame_done_q, frame_done_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           done;
    logic           push;
    logic           pop;
    logic [7:0]     push_data;
    logic           push_sof;
    logic [8:0]     entry_rd [DEPTH];

    // A pixel has finished in the cycle the core's busy flag falls.
    assign l_running_d = core_running;
    assign done        = l_running_q && !core_running;
    assign pop         = out_if.out_ready && (count_q != '0);

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        half_d        = half_q;
        half_valid_d  = half_valid_q;
        sof_pending_d = sof_pending_q;
        run_d         = 1'b0;
        frame_done_d  = 1'b0;
        push          = 1'b0;
        push_data     = 8'h00;
        push_sof      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d       = S_ISSUE;
                    pix_cnt_d     = '0;
                    half_valid_d  = 1'b0;
                    sof_pending_d = 1'b1;
                end
            end
            S_ISSUE: begin
                // A paused frame stays here; only an untouched frame may return to IDLE.
                if (!enable) begin
                    if (pix_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end
                end else if (!core_running && (count_q < DEPTH_C)) begin
                    run_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_running) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (done) begin
                    pix_cnt_d = pix_cnt_q + PCW'(1);
                    if (half_valid_q) begin
                        push          = 1'b1;
                        push_data     = {ctr_in, half_q};
                        push_sof      = sof_pending_q;
                        sof_pending_d = 1'b0;
                        half_valid_d  = 1'b0;
                    end else begin
                        half_d       = ctr_in;
                        half_valid_d = 1'b1;
                    end
                    state_d = (pix_cnt_q == LAST_PIX) ? S_FLUSH : S_ISSUE;
                end
            end
            S_FLUSH: begin
                // Pulse frame_done in the cycle right after the FIFO drains.
                if (half_valid_q) begin
                    push          = 1'b1;
                    push_data     = {4'h0, half_q};
                    push_sof      = sof_pending_q;
                    sof_pending_d = 1'b0;
                    half_valid_d  = 1'b0;
                end else if ((count_q == '0) || ((count_q == CW'(1)) && pop)) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [8:0] entry_q, entry_d;

        always_comb begin
            entry_d = entry_q;
            if (push && (wr_ptr_q == AW'(gi))) begin
                entry_d = {push_sof, push_data};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign entry_rd[gi] = entry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pix_cnt_q     <= '0;
            half_q        <= '0;
            half_valid_q  <= 1'b0;
            sof_pending_q <= 1'b0;
            l_running_q   <= 1'b0;
            run_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            half_q        <= half_d;
            half_valid_q  <= half_valid_d;
            sof_pending_q <= sof_pending_d;
            l_running_q   <= l_running_d;
            run_q         <= run_d;
            frame_done_q  <= frame_done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    assign run                              = run_q;
    assign frame_done                       = frame_done_q;
    assign busy                             = (state_q != S_IDLE);
    assign out_if.out_valid                 = (count_q != '0);
    assign {out_if.out_sof, out_if.out_data} = entry_rd[rd_ptr_q];
endmodule

// File: tb/tb_mandelbrot_pixel_packer.sv
// Three packer instances (4/4, 4/5, 2/8 depth/pixels) each driven by a simple
// core model and checked every cycle against an expected-byte scoreboard.
module tb_mandelbrot_pixel_packer;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n        [N];
    logic       enable       [N];
    logic       out_ready    [N];
    logic       core_running [N] = '{1'b0, 1'b0, 1'b0};
    logic [3:0] ctr_in       [N] = '{4'h0, 4'h0, 4'h0};
    logic       run          [N];
    logic       frame_done   [N];
    logic       busy         [N];
    logic       out_valid    [N];
    logic       out_sof      [N];
    logic [7:0] out_data     [N];

    int core_val [N] = '{1, 1, 1};
    int cyc_left [N] = '{0, 0, 0};
    int run_cnt  [N] = '{0, 0, 0};
    int fd_cnt   [N] = '{0, 0, 0};

    // Scoreboard entry: {last byte of frame, sof, data}
    logic [9:0] exp_q   [N][$];
    logic [8:0] pop_log [N][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected bytes of a frame whose pixels carry consecutive values from 'first'.
    task automatic load_frame(input int k, input int first, input int npix, input bit whole);
        int nbytes;
        logic [3:0] lo, hi;
        nbytes = (npix + 1) / 2;
        for (int b = 0; b < nbytes; b++) begin
            lo = 4'((first + 2 * b) % 16);
            hi = (2 * b + 1 < npix) ? 4'((first + 2 * b + 1) % 16) : 4'h0;
            exp_q[k].push_back({whole && (b == nbytes - 1), (b == 0), hi, lo});
        end
    endtask

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int D = (gi == 2) ? 2 : 4;
        localparam int P = (gi == 0) ? 4 : ((gi == 1) ? 5 : 8);

        mandelbrot_pixel_packer_if u_if ();

        assign u_if.out_ready = out_ready[gi];
        assign out_valid[gi]  = u_if.out_valid;
        assign out_sof[gi]    = u_if.out_sof;
        assign out_data[gi]   = u_if.out_data;

        mandelbrot_pixel_packer #(
            .DEPTH  (D),
            .PIXELS (P)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[gi]),
            .enable       (enable[gi]),
            .core_running (core_running[gi]),
            .ctr_in       (ctr_in[gi]),
            .run          (run[gi]),
            .frame_done   (frame_done[gi]),
            .busy         (busy[gi]),
            .out_if       (u_if)
        );

        // Core model: starts on run, busy for 10 cycles, returns the next value.
        always @(posedge clk) begin
            if (core_running[gi]) begin
                if (cyc_left[gi] <= 1) begin
                    core_running[gi] <= 1'b0;
                    ctr_in[gi]       <= 4'(core_val[gi]);
                    core_val[gi]     <= core_val[gi] + 1;
                end
                cyc_left[gi] <= cyc_left[gi] - 1;
            end else if (run[gi]) begin
                core_running[gi] <= 1'b1;
                cyc_left[gi]     <= 10;
            end
        end

        initial begin : chk_proc
            logic       fd_pend;
            logic [9:0] head;
            fd_pend = 1'b0;
            forever begin
                @(negedge clk);
                #1;
                if (rst_n[gi] !== 1'b1) begin
                    exp_q[gi].delete();
                    fd_pend = 1'b0;
                end else begin
                    chk($sformatf("frame_done[%0d]", gi), frame_done[gi], fd_pend);
                    fd_pend = 1'b0;
                    if (run[gi]) run_cnt[gi]++;
                    if (frame_done[gi]) fd_cnt[gi]++;
                    chk($sformatf("fifo_bound[%0d]", gi), 32'(u_dut.count_q <= D), 1);
                    if (out_valid[gi]) begin
                        chk($sformatf("byte_expected[%0d]", gi), 32'(exp_q[gi].size() != 0), 1);
                        if (exp_q[gi].size() != 0) begin
                            head = exp_q[gi][0];
                            chk($sformatf("out_data[%0d]", gi), out_data[gi], head[7:0]);
                            chk($sformatf("out_sof[%0d]", gi), out_sof[gi], head[8]);
                            if (out_ready[gi]) begin
                                void'(exp_q[gi].pop_front());
                                pop_log[gi].push_back({out_sof[gi], out_data[gi]});
                                fd_pend = head[9];
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_runs(input int k, input int target);
        int n;
        n = 0;
        while (run_cnt[k] < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("runs_reached[%0d]", k), 32'(run_cnt[k] >= target), 1);
    endtask

    task automatic wait_fd(input int k);
        int n;
        n = 0;
        while (frame_done[k] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("frame_done_seen[%0d]", k), frame_done[k], 1);
    endtask

    task automatic wait_fall(input int k);
        int n;
        logic prev, hit;
        n = 0;
        hit = 1'b0;
        prev = core_running[k];
        while (!hit && n < 60) begin
            @(negedge clk);
            hit = prev && !core_running[k];
            prev = core_running[k];
            n++;
        end
        chk($sformatf("core_fall_seen[%0d]", k), hit, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r, f, b, first;
        logic seen;
        for (int k = 0; k < N; k++) begin
            rst_n[k]     = 1'b0;
            enable[k]    = 1'b0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_run[%0d]", k), run[k], 0);
            chk($sformatf("rst_frame_done[%0d]", k), frame_done[k], 0);
            chk($sformatf("rst_out_valid[%0d]", k), out_valid[k], 0);
            chk($sformatf("rst_out_data[%0d]", k), out_data[k], 0);
            chk($sformatf("rst_out_sof[%0d]", k), out_sof[k], 0);
            chk($sformatf("rst_busy[%0d]", k), busy[k], 0);
            rst_n[k] = 1'b1;
        end
        @(negedge clk);

        // Basic frame, 4 pixels valued 1..4
        load_frame(0, 1, 4, 1'b1);
        out_ready[0] = 1'b1;
        r = run_cnt[0];
        f = fd_cnt[0];
        enable[0] = 1'b1;
        wait_runs(0, r + 4);
        enable[0] = 1'b0;
        wait_fd(0);
        repeat (5) @(negedge clk);
        chk("basic_runs", run_cnt[0] - r, 4);
        chk("basic_frame_done_count", fd_cnt[0] - f, 1);
        chk("basic_byte0", pop_log[0][0], 9'h121);
        chk("basic_byte1", pop_log[0][1], 9'h043);
        chk("basic_drained", exp_q[0].size(), 0);
        chk("basic_idle", busy[0], 0);

        // Odd frame, 5 pixels valued 1..5
        load_frame(1, 1, 5, 1'b1);
        out_ready[1] = 1'b1;
        r = run_cnt[1];
        enable[1] = 1'b1;
        wait_runs(1, r + 5);
        enable[1] = 1'b0;
        wait_fd(1);
        repeat (3) @(negedge clk);
        chk("odd_runs", run_cnt[1] - r, 5);
        chk("odd_byte0", pop_log[1][0], 9'h121);
        chk("odd_byte1", pop_log[1][1], 9'h043);
        chk("odd_byte2", pop_log[1][2], 9'h005);
        chk("odd_drained", exp_q[1].size(), 0);

        // Back-pressure with a 2-deep FIFO, then a push coinciding with a pop
        load_frame(2, 1, 8, 1'b1);
        out_ready[2] = 1'b0;
        r = run_cnt[2];
        enable[2] = 1'b1;
        repeat (120) @(negedge clk);
        chk("bp_runs_stalled", run_cnt[2] - r, 4);
        chk("bp_run_low", run[2], 0);
        chk("bp_head_data", out_data[2], 8'h21);
        chk("bp_head_sof", out_sof[2], 1);
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;
        seen = run[2];
        @(negedge clk);
        seen = seen | run[2];
        chk("bp_resume_run", seen, 1);
        wait_fall(2);
        wait_fall(2);
        out_ready[2] = 1'b1;
        chk("simul_head_before", out_data[2], 8'h43);
        @(negedge clk);
        out_ready[2] = 1'b0;
        chk("simul_valid_after", out_valid[2], 1);
        chk("simul_new_head", out_data[2], 8'h65);
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;
        chk("simul_count_was_one", out_valid[2], 0);
        out_ready[2] = 1'b1;
        wait_runs(2, r + 8);
        enable[2] = 1'b0;
        wait_fd(2);
        repeat (3) @(negedge clk);
        chk("bp_byte2", pop_log[2][2], 9'h065);
        chk("bp_byte3", pop_log[2][3], 9'h087);
        chk("bp_drained", exp_q[2].size(), 0);

        // Pause after the first pixel, then resume
        b = pop_log[0].size();
        first = core_val[0];
        load_frame(0, first, 4, 1'b1);
        r = run_cnt[0];
        enable[0] = 1'b1;
        wait_runs(0, r + 1);
        enable[0] = 1'b0;
        repeat (60) @(negedge clk);
        chk("pause_runs", run_cnt[0] - r, 1);
        chk("pause_busy", busy[0], 1);
        chk("pause_no_byte", out_valid[0], 0);
        enable[0] = 1'b1;
        wait_runs(0, r + 4);
        enable[0] = 1'b0;
        wait_fd(0);
        repeat (3) @(negedge clk);
        chk("pause_byte0", pop_log[0][b], 9'h165);
        chk("pause_byte1", pop_log[0][b + 1], 9'h087);

        // Reset in BUSY with a byte waiting on the output
        out_ready[0] = 1'b0;
        load_frame(0, core_val[0], 2, 1'b0);
        r = run_cnt[0];
        enable[0] = 1'b1;
        wait_runs(0, r + 3);
        repeat (4) @(negedge clk);
        chk("prereset_head", out_data[0], 8'hA9);
        rst_n[0]  = 1'b0;
        enable[0] = 1'b0;
        @(negedge clk);
        chk("midrst_run", run[0], 0);
        chk("midrst_frame_done", frame_done[0], 0);
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_out_data", out_data[0], 0);
        chk("midrst_out_sof", out_sof[0], 0);
        chk("midrst_busy", busy[0], 0);
        rst_n[0] = 1'b1;
        wait_fall(0);
        repeat (3) @(negedge clk);
        chk("postrst_no_push", out_valid[0], 0);
        chk("postrst_idle", busy[0], 0);
        b = pop_log[0].size();
        load_frame(0, core_val[0], 4, 1'b1);
        out_ready[0] = 1'b1;
        r = run_cnt[0];
        enable[0] = 1'b1;
        wait_runs(0, r + 4);
        enable[0] = 1'b0;
        wait_fd(0);
        repeat (3) @(negedge clk);
        chk("postrst_byte0", pop_log[0][b], 9'h1DC);
        chk("postrst_byte1", pop_log[0][b + 1], 9'h0FE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mandelbrot_pixel_packer.md
Name: mandelbrot_pixel_packer

Overview:
- Sits directly downstream of the Mandelbrot iteration core and paces it.
- Issues one `run` strobe per pixel and captures each finished 4-bit iteration value.
- Packs two pixels per byte into a small FIFO and presents bytes on a valid/ready output port.
- Applies back-pressure: the core is never started unless the FIFO can accept the resulting byte.

Parameters:
- DEPTH, 4, FIFO depth in bytes (power of two, >=2).
- PIXELS, 76800, pixels per frame (WIDTH*HEIGHT of core).
- PCW, $clog2(PIXELS+1), pixel counter width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; frames are generated while high.
- core_running  in  1  core busy flag.
- ctr_in  in  4  core pixel value; valid in the cycle core_running falls.
- run  out  1  one-cycle start strobe to the core.
- out_data  out  8  packed byte: low nibble = earlier pixel, high nibble = later pixel.
- out_sof  out  1  qualifies out_data as the first byte of a frame.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is popped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async):
  - run=0, frame_done=0, out_valid=0, out_data=0, out_sof=0, busy=0.
  - FIFO empty, pixel counter 0, half-byte register empty, state IDLE.
- Pixel-done detect:
  - Register l_running <= core_running.
  - done = l_running && !core_running.
  - Capture ctr_in in that cycle.
- FSM:
  - IDLE: if enable -> ISSUE; clear pixel counter; set sof_pending=1.
  - ISSUE:
    - When !core_running and fifo_count < DEPTH: assert run for exactly 1 cycle, then go to WAIT.
    - If enable=0: -> IDLE only when pixel counter=0; otherwise hold in ISSUE without issuing (pause/resume mid-frame).
  - WAIT: wait for core_running=1, then -> BUSY. Max 2 cycles; no timeout required.
  - BUSY:
    - On done: increment pixel counter and pack.
    - If counter+1 == PIXELS -> FLUSH, else -> ISSUE.
  - FLUSH:
    - If the half-byte is still held (PIXELS odd): push {4'h0, half} in the first FLUSH cycle.
    - Then wait for FIFO empty, pulse frame_done for 1 cycle, -> IDLE.
- Packing:
  - First pixel of a pair goes to the half register.
  - Second pixel pushes {ctr_in, half} with sof = sof_pending; sof_pending is then cleared.
  - At most one push per pixel, so the ISSUE guard (count < DEPTH) makes overflow impossible. The bench asserts it never occurs.
- FIFO:
  - Pointers are $clog2(DEPTH) bits and wrap; count is $clog2(DEPTH)+1 bits.
  - out_data/out_sof are driven combinationally from the head entry (show-ahead); out_valid = count != 0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop while empty: ignored.
  - out_data/out_sof are stable while out_valid && !out_ready.
- frame_done:
  - Pulses in the cycle after the final pop.
  - Never pulses when the frame has 0 popped bytes.
- Latency: done edge to out_valid = 1 cycle when the FIFO is empty and the byte completes.
- Reset mid-frame: everything returns to reset values immediately.
  - A byte being presented is lost.
  - A core still running finishes unobserved: the done edge is ignored because state=IDLE.
- enable dropped in BUSY/WAIT/FLUSH: the current pixel and the flush complete; the pause takes effect only in ISSUE.

Test Plan:
- Basic frame (PIXELS=4, DEPTH=4), core model returns 1,2,3,4 after 10 cycles each, out_ready=1:
  - Bytes 0x21 with out_sof=1, then 0x43 with out_sof=0.
  - frame_done pulses once; exactly 4 run strobes.
- Odd frame (PIXELS=5), values 1..5:
  - Bytes 0x21 (sof), 0x43, 0x05; frame_done after the third pop.
- Back-pressure (DEPTH=2, PIXELS=8), out_ready=0:
  - After 4 pixels, run stays low and the FIFO holds 0x21, 0x43.
  - Raising out_ready resumes run within 2 cycles.
  - Order is preserved; no push occurs while count=DEPTH.
- Simultaneous push/pop (DEPTH=2), count=1, byte completes in the cycle it is popped:
  - count stays 1; the next out_data is the new byte.
- Pause: drop enable after pixel 1 of 4:
  - Pixel 1 completes; no further run while enable=0.
  - Re-enable: pixels 2..4 complete with no second sof.
- Reset mid-frame during BUSY:
  - All outputs return to 0 and state is IDLE.
  - The subsequent core done edge produces no push.
  - The next enable starts a new frame with out_sof=1.
